// File: rtl/uart_work_sender_pkg.sv
// Shared constants and state encodings for the 0xAA/0x55 UART mining protocol.
package uart_work_sender_pkg;

    localparam logic [7:0] HDR_REQ   = 8'hAA;
    localparam logic [7:0] HDR_RESP  = 8'h55;
    localparam logic [7:0] CMD_WORK  = 8'h00;
    localparam logic [7:0] CMD_FOUND = 8'h00;
    localparam logic [7:0] CMD_LOOP  = 8'h01;
    localparam logic [7:0] CMD_ACK   = 8'h01;
    localparam logic [7:0] WORK_LEN  = 8'd84;
    localparam logic [7:0] FOUND_LEN = 8'd4;
    localparam logic [7:0] LOOP_LEN  = 8'd1;

    localparam int unsigned PAYLOAD_W = 672;

    typedef enum logic [2:0] {TX_IDL, TX_HDR, TX_CMD, TX_LEN, TX_DAT} tx_state_t;
    typedef enum logic [1:0] {RX_IDL, RX_CMD, RX_LEN, RX_DAT} rx_state_t;

endpackage

// File: rtl/uart_work_sender_resp_decoder.sv
// Response-frame parser (found nonce / loop ack) for the UART mining protocol.
// Optional inter-byte timeout enabled by UART_WORK_SENDER_RX_TIMEOUT_EN.
module uart_resp_decoder
    import uart_work_sender_pkg::*;
`ifdef UART_WORK_SENDER_RX_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic        found,
    output logic [31:0] nonce,
    output logic        loop_ack,
    output logic [7:0]  loop_ack_data,
    output logic        frame_err
);

    rx_state_t   state_q, state_d;
    logic        is_ack_q, is_ack_d;
    logic        len_ok_q, len_ok_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] nonce_q, nonce_d;
    logic [7:0]  ack_data_q, ack_data_d;
    logic        found_q, found_d;
    logic        loop_ack_q, loop_ack_d;
    logic        err_q, err_d;
    logic        tmo_hit;

`ifdef UART_WORK_SENDER_RX_TIMEOUT_EN
    logic [31:0] tmo_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            tmo_q <= '0;
        else if (new_rx_data || state_q == RX_IDL)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 32'd1;
    end

    assign tmo_hit = (state_q != RX_IDL) && !new_rx_data && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_ack_d   = is_ack_q;
        len_ok_d   = len_ok_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        nonce_d    = nonce_q;
        ack_data_d = ack_data_q;
        found_d    = 1'b0;
        loop_ack_d = 1'b0;
        err_d      = 1'b0;
        if (tmo_hit) begin
            state_d = RX_IDL;
            err_d   = 1'b1;
        end else if (new_rx_data) begin
            case (state_q)
                RX_IDL: if (rx_data == HDR_RESP) state_d = RX_CMD;
                RX_CMD: begin
                    if (rx_data == CMD_FOUND || rx_data == CMD_ACK) begin
                        is_ack_d = (rx_data == CMD_ACK);
                        state_d  = RX_LEN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RX_IDL;
                    end
                end
                RX_LEN: begin
                    // A length byte of 0 wraps the down-counter through 256 bytes.
                    cnt_d    = rx_data;
                    len_ok_d = is_ack_q ? (rx_data == LOOP_LEN) : (rx_data == FOUND_LEN);
                    state_d  = RX_DAT;
                end
                RX_DAT: begin
                    data_d = {rx_data, data_q[31:8]};
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = RX_IDL;
                        if (!len_ok_q) begin
                            err_d = 1'b1;
                        end else if (is_ack_q) begin
                            ack_data_d = rx_data;
                            loop_ack_d = 1'b1;
                        end else begin
                            nonce_d = {rx_data, data_q[31:8]};
                            found_d = 1'b1;
                        end
                    end
                end
                default: state_d = RX_IDL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RX_IDL;
            is_ack_q   <= 1'b0;
            len_ok_q   <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            nonce_q    <= '0;
            ack_data_q <= '0;
            found_q    <= 1'b0;
            loop_ack_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_ack_q   <= is_ack_d;
            len_ok_q   <= len_ok_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            nonce_q    <= nonce_d;
            ack_data_q <= ack_data_d;
            found_q    <= found_d;
            loop_ack_q <= loop_ack_d;
            err_q      <= err_d;
        end
    end

    assign found         = found_q;
    assign nonce         = nonce_q;
    assign loop_ack      = loop_ack_q;
    assign loop_ack_data = ack_data_q;
    assign frame_err     = err_q;

endmodule

// File: rtl/uart_work_sender.sv
// Host-side initiator: serializes work/loop command frames and decodes responses.
// RX inter-byte timeout is enabled by defining UART_WORK_SENDER_RX_TIMEOUT_EN.
module uart_work_sender
    import uart_work_sender_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [639:0] work,
    input  logic [31:0]  target,
    input  logic         loop_valid,
    output logic         loop_ready,
    input  logic [7:0]   loop_data,
    output logic [7:0]   tx_data,
    output logic         new_tx_data,
    input  logic         tx_busy,
    input  logic [7:0]   rx_data,
    input  logic         new_rx_data,
    output logic         found,
    output logic [31:0]  nonce,
    output logic         loop_ack,
    output logic [7:0]   loop_ack_data,
    output logic         frame_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    tx_state_t              state_q, state_d;
    logic [PAYLOAD_W-1:0]   shift_q, shift_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   tx_busy_q;
    logic                   tx_fall;

    assign tx_fall    = tx_busy_q && !tx_busy;
    assign work_ready = (state_q == TX_IDL);
    assign loop_ready = (state_q == TX_IDL) && !work_valid;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tx_data     = 8'h00;
        new_tx_data = 1'b0;
        case (state_q)
            TX_IDL: begin
                if (work_valid) begin
                    shift_d = {target, work};
                    cmd_d   = CMD_WORK;
                    len_d   = WORK_LEN;
                    state_d = TX_HDR;
                end else if (loop_valid) begin
                    shift_d = {{(PAYLOAD_W-8){1'b0}}, loop_data};
                    cmd_d   = CMD_LOOP;
                    len_d   = LOOP_LEN;
                    state_d = TX_HDR;
                end
            end
            // The header only needs an idle transmitter; later bytes wait for busy to fall.
            TX_HDR: if (!tx_busy) begin
                tx_data     = HDR_REQ;
                new_tx_data = 1'b1;
                state_d     = TX_CMD;
            end
            TX_CMD: if (tx_fall) begin
                tx_data     = cmd_q;
                new_tx_data = 1'b1;
                state_d     = TX_LEN;
            end
            TX_LEN: if (tx_fall) begin
                tx_data     = len_q;
                new_tx_data = 1'b1;
                cnt_d       = len_q;
                state_d     = TX_DAT;
            end
            TX_DAT: if (tx_fall) begin
                tx_data     = shift_q[7:0];
                new_tx_data = 1'b1;
                shift_d     = shift_q >> 8;
                cnt_d       = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = TX_IDL;
            end
            default: state_d = TX_IDL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDL;
            shift_q   <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tx_busy_q <= tx_busy;
        end
    end

    uart_resp_decoder
`ifdef UART_WORK_SENDER_RX_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_resp_decoder (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .new_rx_data   (new_rx_data),
        .found         (found),
        .nonce         (nonce),
        .loop_ack      (loop_ack),
        .loop_ack_data (loop_ack_data),
        .frame_err     (frame_err)
    );

endmodule

// File: tb/tb_uart_work_sender.sv
// Scoreboard bench for uart_work_sender: random TX requests and RX frames against a byte-level model.
module tb_uart_work_sender;

    localparam int TMO = 50;

    logic         clock = 1'b0;
    logic         reset;
    logic         work_valid, loop_valid;
    logic         work_ready, loop_ready;
    logic [639:0] work;
    logic [31:0]  target;
    logic [7:0]   loop_data;
    logic [7:0]   tx_data;
    logic         new_tx_data;
    logic         tx_busy = 1'b0;
    logic [7:0]   rx_data;
    logic         new_rx_data;
    logic         found, loop_ack, frame_err;
    logic [31:0]  nonce;
    logic [7:0]   loop_ack_data;

    always #5 clock = ~clock;

    uart_work_sender #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .work_valid(work_valid), .work_ready(work_ready), .work(work), .target(target),
        .loop_valid(loop_valid), .loop_ready(loop_ready), .loop_data(loop_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .rx_data(rx_data), .new_rx_data(new_rx_data),
        .found(found), .nonce(nonce), .loop_ack(loop_ack), .loop_ack_data(loop_ack_data),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 found, 1 loop ack, 2 frame error
        logic [31:0] val;
    } ev_t;

    logic [7:0] tx_exp[$];
    ev_t        rx_exp[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cyc = 0;
    int tx_count = 0;
    int busy_cnt = 0;
    logic strobe_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rx_pop(input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got kind %0d value %h expected no event", k, v);
        end else begin
            e = rx_exp.pop_front();
            chk("rx_kind", 32'(k), 32'(e.kind));
            if (k == e.kind && k != 2'd2) chk("rx_value", v, e.val);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a byte or an event.
    always @(negedge clock) begin
        cyc++;
        strobe_seen = new_tx_data;
        if (new_tx_data) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got byte %h expected no strobe", tx_data);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(tx_exp.pop_front()));
                tx_count++;
            end
        end else if (tx_data != 8'h00) begin
            chk("tx_data_idle", 32'(tx_data), 32'h0);
        end
        if (found)     rx_pop(2'd0, nonce);
        if (loop_ack)  rx_pop(2'd1, {24'd0, loop_ack_data});
        if (frame_err) begin
            err_cyc = cyc;
            rx_pop(2'd2, 32'd0);
        end
    end

    // Transmitter model: busy for 10 cycles after each accepted byte.
    always @(posedge clock) begin
        #1;
        if (strobe_seen) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_work(input logic [639:0] w, input logic [31:0] t);
        tx_exp.push_back(8'hAA);
        tx_exp.push_back(8'h00);
        tx_exp.push_back(8'd84);
        for (int i = 0; i < 80; i++) tx_exp.push_back(w[8*i +: 8]);
        for (int i = 0; i < 4; i++)  tx_exp.push_back(t[8*i +: 8]);
    endtask

    task automatic push_loop(input logic [7:0] d);
        tx_exp.push_back(8'hAA);
        tx_exp.push_back(8'h01);
        tx_exp.push_back(8'h01);
        tx_exp.push_back(d);
    endtask

    task automatic wait_accept(input bit is_loop);
        int n = 0;
        while (n < 5000) begin
            @(negedge clock);
            if (is_loop ? loop_ready : work_ready) break;
            n++;
        end
        if (n >= 5000) chk("accept_timeout", 32'(n), 32'd0);
        tick();
    endtask

    task automatic req_work(input logic [639:0] w, input logic [31:0] t);
        push_work(w, t);
        work = w;
        target = t;
        work_valid = 1'b1;
        wait_accept(1'b0);
        work_valid = 1'b0;
    endtask

    task automatic req_loop(input logic [7:0] d);
        push_loop(d);
        loop_data = d;
        loop_valid = 1'b1;
        wait_accept(1'b1);
        loop_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input bit chk_ready);
        int n = 0;
        bit rdy_bad = 1'b0;
        while (tx_exp.size() != 0 && n < 20000) begin
            @(negedge clock);
            if (chk_ready && tx_exp.size() != 0 && work_ready) rdy_bad = 1'b1;
            n++;
        end
        if (n >= 20000) chk("tx_drain_timeout", 32'(tx_exp.size()), 32'd0);
        if (chk_ready) chk("work_ready_low_in_frame", 32'(rdy_bad), 32'd0);
        tick();
    endtask

    task automatic wait_rx_done();
        int n = 0;
        while (rx_exp.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("rx_event_timeout", 32'(rx_exp.size()), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Reference model for one response frame: outcome depends only on cmd and len.
    task automatic rx_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] pay);
        ev_t e;
        int n;
        if (cmd > 8'h01) begin
            e.kind = 2'd2; e.val = 32'd0;
            rx_exp.push_back(e);
            send_rx(8'h55);
            send_rx(cmd);
            return;
        end
        n = (len == 8'd0) ? 256 : int'(len);
        if (cmd == 8'h00 && len == 8'd4)      begin e.kind = 2'd0; e.val = pay; end
        else if (cmd == 8'h01 && len == 8'd1) begin e.kind = 2'd1; e.val = {24'd0, pay[7:0]}; end
        else                                  begin e.kind = 2'd2; e.val = 32'd0; end
        rx_exp.push_back(e);
        send_rx(8'h55);
        send_rx(cmd);
        send_rx(len);
        for (int i = 0; i < n; i++) send_rx(i < 4 ? pay[8*i +: 8] : 8'($urandom()));
    endtask

    function automatic logic [639:0] rand_work();
        logic [639:0] w;
        for (int i = 0; i < 20; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [639:0] w;
        logic [7:0]   b;
        int start;
        ev_t e;
        reset = 1'b1;
        work_valid = 1'b0; loop_valid = 1'b0;
        work = '0; target = '0; loop_data = '0;
        rx_data = '0; new_rx_data = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_work_ready", 32'(work_ready), 32'd1);
        chk("rst_loop_ready", 32'(loop_ready), 32'd1);
        chk("rst_new_tx_data", 32'(new_tx_data), 32'd0);
        chk("rst_nonce", nonce, 32'd0);
        chk("rst_loop_ack_data", 32'(loop_ack_data), 32'd0);
        chk("rst_pulses", {29'd0, found, loop_ack, frame_err}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed work frame, then random ones.
        w = rand_work();
        w[15:0] = 16'h0102;
        req_work(w, 32'hDEADBEEF);
        wait_tx_done(1'b1);
        @(negedge clock);
        chk("work_ready_after_frame", 32'(work_ready), 32'd1);
        tick();
        req_work(rand_work(), $urandom());
        wait_tx_done(1'b1);

        // Loop request and its acknowledgement.
        req_loop(8'h3C);
        wait_tx_done(1'b0);
        rx_frame(8'h01, 8'h01, 32'h3D);
        wait_rx_done();
        req_loop(8'($urandom()));
        wait_tx_done(1'b0);

        // Found frames and protocol errors.
        rx_frame(8'h00, 8'h04, 32'h12345678);
        rx_frame(8'h07, 8'h00, 32'h0);
        rx_frame(8'h00, 8'h02, 32'h0000BBAA);
        rx_frame(8'h00, 8'h04, $urandom());
        rx_frame(8'h01, 8'h02, $urandom());
        rx_frame(8'h00, 8'h00, $urandom());
        rx_frame(8'h01, 8'h01, $urandom());
        wait_rx_done();
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 4))
                0: rx_frame(8'h00, 8'h04, $urandom());
                1: rx_frame(8'h01, 8'h01, $urandom());
                2: rx_frame(8'($urandom_range(2, 255)), 8'h00, 32'h0);
                3: rx_frame(8'($urandom_range(0, 1)), 8'($urandom_range(5, 9)), $urandom());
                default: begin
                    b = 8'($urandom());
                    if (b == 8'h55) b = 8'h54;
                    send_rx(b);
                    rx_frame(8'h00, 8'h04, $urandom());
                end
            endcase
        end
        wait_rx_done();

        // Full duplex: a found frame arrives while a work frame is going out.
        fork
            begin
                req_work(rand_work(), $urandom());
                wait_tx_done(1'b0);
            end
            begin
                repeat (100) tick();
                rx_frame(8'h00, 8'h04, $urandom());
                rx_frame(8'h01, 8'h01, $urandom());
            end
        join
        wait_rx_done();

        // Simultaneous requests: work first, loop afterwards.
        w = rand_work();
        b = 8'($urandom());
        push_work(w, 32'hCAFEF00D);
        push_loop(b);
        work = w; target = 32'hCAFEF00D; loop_data = b;
        work_valid = 1'b1;
        loop_valid = 1'b1;
        @(negedge clock);
        chk("arb_loop_ready_blocked", 32'(loop_ready), 32'd0);
        chk("arb_work_ready", 32'(work_ready), 32'd1);
        tick();
        work_valid = 1'b0;
        wait_accept(1'b1);
        loop_valid = 1'b0;
        wait_tx_done(1'b0);

        // Reset in the middle of a work frame drops it.
        tx_count = 0;
        req_work(rand_work(), $urandom());
        start = 0;
        while (tx_count < 40 && start < 5000) begin
            tick();
            start++;
        end
        chk("reached_byte_40", 32'(tx_count >= 40), 32'd1);
        reset = 1'b1;
        tx_exp.delete();
        repeat (3) begin
            @(negedge clock);
            chk("midrst_no_strobe", 32'(new_tx_data), 32'd0);
            chk("midrst_work_ready", 32'(work_ready), 32'd1);
        end
        tick();
        reset = 1'b0;
        repeat (30) tick();
        @(negedge clock);
        chk("post_rst_work_ready", 32'(work_ready), 32'd1);
        tick();
        req_loop(8'($urandom()));
        wait_tx_done(1'b0);

`ifdef UART_WORK_SENDER_RX_TIMEOUT_EN
        e.kind = 2'd2; e.val = 32'd0;
        rx_exp.push_back(e);
        send_rx(8'h55);
        rx_data = 8'h00;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        start = cyc;
        repeat (TMO + 10) tick();
        chk("timeout_fired", 32'(rx_exp.size()), 32'd0);
        chk("timeout_latency_ok", 32'((err_cyc - start) >= TMO - 1 && (err_cyc - start) <= TMO + 2), 32'd1);
        rx_frame(8'h01, 8'h01, 32'h0);
        wait_rx_done();
`else
        send_rx(8'h55);
        send_rx(8'h00);
        repeat (300) tick();
        chk("no_timeout_event", 32'(rx_exp.size()), 32'd0);
        e.kind = 2'd0; e.val = 32'hA5B6C7D8;
        rx_exp.push_back(e);
        send_rx(8'h04);
        send_rx(8'hD8);
        send_rx(8'hC7);
        send_rx(8'hB6);
        send_rx(8'hA5);
        wait_rx_done();
`endif

        repeat (20) tick();
        chk("tx_scoreboard_empty", 32'(tx_exp.size()), 32'd0);
        chk("rx_scoreboard_empty", 32'(rx_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
